// File: rtl/sensor_emu_gen_mc.sv
// Sensor-frame emulator: idle pattern or framed header/data/footer on a wide LVDS bus.
// Each frame consumes one pattern word from AXI-Stream at its start point.
`timescale 1ns/1ps

module sensor_emu_lane #(
    parameter int LANE = 0
) (
    input  logic [7:0]  byte_val,
    input  logic        idx_mode,
    output logic [63:0] lane_out
);
    for (genvar b = 0; b < 8; b++) begin : g_byte
        assign lane_out[8*b +: 8] = idx_mode ? 8'(LANE*8 + b) : byte_val;
    end
endmodule

module sensor_emu_gen_mc #(
    parameter int LVDS_WIDTH        = 512,
    parameter int PATTERN_WIDTH     = 32,
    parameter int SYNC_PERIOD_LOG2  = 8,
    parameter int SYNC_PULSE_LENGTH = 4,
    parameter int HEADER_CYCLES     = 16,
    parameter int FOOTER_CYCLES     = 4,
    parameter int CELL_REPEAT       = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     rs0,
    input  logic                     rs256,
    input  logic [31:0]              cycles_per_frame,
    input  logic [7:0]               idle_0,
    input  logic [7:0]               idle_1,
    input  logic [31:0]              frame_header,
    input  logic [7:0]               footer_byte,
    output logic                     pa_sync,
    output logic [LVDS_WIDTH-1:0]    lvds,
    output logic                     sof,
    output logic                     eof,
    output logic [31:0]              frame_count,
    output logic [15:0]              underflow_count,
    input  logic [PATTERN_WIDTH-1:0] PATTERN_TDATA,
    input  logic                     PATTERN_TVALID,
    output logic                     PATTERN_TREADY
);
    localparam int NUM_LANES = LVDS_WIDTH / 64;
    localparam int CR_LOG2   = $clog2(CELL_REPEAT);
    localparam logic [31:0] MIN_LEN  = 32'(HEADER_CYCLES + FOOTER_CYCLES + 2);
    localparam logic [31:0] HDR_LAST = 32'(HEADER_CYCLES - 1);
    localparam logic [31:0] FTR_LEN  = 32'(FOOTER_CYCLES);
    localparam logic [SYNC_PERIOD_LOG2-1:0] PULSE_LEN = SYNC_PERIOD_LOG2'(SYNC_PULSE_LENGTH);

    typedef enum logic [2:0] {S_RESET, S_IDLE0, S_IDLE1, S_HDR, S_DATA, S_FTR} state_t;

    // Everything a frame needs is frozen at its start so mid-frame input changes are ignored.
    typedef struct packed {
        logic [31:0] len;
        logic [31:0] seq;
        logic [63:0] pattern;
        logic [31:0] header;
        logic [7:0]  footer;
    } frame_ctx_t;

    state_t                      state, state_nxt;
    frame_ctx_t                  ctx;
    logic [31:0]                 cycle_number;
    logic [SYNC_PERIOD_LOG2-1:0] free_timer;
    logic                        trigger, last_cycle, start_point, accept, underflow;
    logic [7:0]                  byte_val;
    logic                        idx_mode;
    logic [NUM_LANES-1:0][63:0]  lanes;

    assign trigger     = enable & (rs0 | rs256) & (free_timer == '0);
    assign last_cycle  = (state == S_FTR) && (cycle_number == ctx.len - 32'd1);
    assign start_point = (state == S_IDLE1) || last_cycle;
    assign accept      = start_point & trigger & PATTERN_TVALID;
    assign underflow   = start_point & trigger & ~PATTERN_TVALID;

    assign PATTERN_TREADY = accept;
    // Held low in RESET so the sync output is quiet while the block is reset.
    assign pa_sync = enable & (free_timer < PULSE_LEN) & (state != S_RESET);
    assign sof     = (state == S_HDR);
    assign eof     = (state == S_FTR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) free_timer <= '0;
        else         free_timer <= free_timer + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_RESET;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = S_IDLE0;
            S_IDLE0: state_nxt = S_IDLE1;
            S_IDLE1: state_nxt = accept ? S_HDR : S_IDLE0;
            S_HDR:   if (cycle_number == HDR_LAST) state_nxt = S_DATA;
            S_DATA:  if (cycle_number == ctx.len - 32'd1 - FTR_LEN) state_nxt = S_FTR;
            S_FTR:   if (last_cycle) state_nxt = accept ? S_HDR : S_IDLE0;
            default: state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctx             <= '0;
            cycle_number    <= '0;
            frame_count     <= '0;
            underflow_count <= '0;
        end else begin
            if (accept) begin
                ctx.len      <= (cycles_per_frame < MIN_LEN) ? MIN_LEN : cycles_per_frame;
                ctx.seq      <= frame_count;
                ctx.pattern  <= {(64/PATTERN_WIDTH){PATTERN_TDATA}};
                ctx.header   <= frame_header;
                ctx.footer   <= footer_byte;
                frame_count  <= frame_count + 32'd1;
                cycle_number <= '0;
            end else if (state == S_HDR || state == S_DATA || state == S_FTR) begin
                cycle_number <= cycle_number + 32'd1;
            end
            if (underflow && underflow_count != 16'hFFFF)
                underflow_count <= underflow_count + 16'd1;
        end
    end

    // One byte value per cycle, broadcast to every byte lane (cycle 8 of the header is the exception).
    always_comb begin
        byte_val = '0;
        idx_mode = 1'b0;
        case (state)
            S_IDLE0: byte_val = idle_0;
            S_IDLE1: byte_val = idle_1;
            S_HDR: begin
                if (cycle_number < 32'd4)
                    byte_val = ctx.header[{cycle_number[1:0], 3'b000} +: 8];
                else if (cycle_number < 32'd8)
                    byte_val = ctx.seq[{cycle_number[1:0], 3'b000} +: 8];
                else if (cycle_number == 32'd8)
                    idx_mode = 1'b1;
            end
            // Pattern bytes are taken MSB first: byte k sits at bit 63-8k.
            S_DATA:  byte_val = ctx.pattern[{~cycle_number[CR_LOG2 +: 3], 3'b000} +: 8];
            S_FTR:   byte_val = ctx.footer;
            default: ;
        endcase
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        sensor_emu_lane #(.LANE(l)) u_lane (
            .byte_val (byte_val),
            .idx_mode (idx_mode),
            .lane_out (lanes[l])
        );
    end

    assign lvds = lanes;
endmodule

// File: tb/tb_sensor_emu_gen_mc.sv
// Bench for sensor_emu_gen_mc: position-based frame model compared every cycle,
// directed scenarios with literal expectations, then a long randomized run.
`timescale 1ns/1ps

module tb_sensor_emu_gen_mc;
    localparam int LW = 512, PW = 32, H = 16, F = 4, CR = 4, PLEN = 4;

    logic          clk = 1'b0, resetn = 1'b0, enable = 1'b0, rs0 = 1'b0, rs256 = 1'b0;
    logic [31:0]   cpf = 32'd64, frame_header = 32'h0, frame_count;
    logic [7:0]    idle_0 = 8'h55, idle_1 = 8'hAA, footer_byte = 8'hEE;
    logic          pa_sync, sof, eof, tvalid = 1'b0, tready;
    logic [LW-1:0] lvds;
    logic [15:0]   underflow_count;
    logic [PW-1:0] tdata = '0;

    int unsigned errors = 0, checks = 0;

    sensor_emu_gen_mc dut (
        .clk(clk), .resetn(resetn), .enable(enable), .rs0(rs0), .rs256(rs256),
        .cycles_per_frame(cpf), .idle_0(idle_0), .idle_1(idle_1),
        .frame_header(frame_header), .footer_byte(footer_byte), .pa_sync(pa_sync),
        .lvds(lvds), .sof(sof), .eof(eof), .frame_count(frame_count),
        .underflow_count(underflow_count), .PATTERN_TDATA(tdata),
        .PATTERN_TVALID(tvalid), .PATTERN_TREADY(tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame = position counter over [header | data | footer]; idle alternates by parity.
    bit          m_rst = 1'b1, m_in = 1'b0, m_odd = 1'b0;
    logic [31:0] m_pos = '0, m_len = '0, m_seq = '0, m_hdr = '0, m_frames = '0;
    logic [63:0] m_pat = '0;
    logic [7:0]  m_ftr = '0, m_ft = '0;
    int unsigned m_und = 0;

    function automatic bit m_start();
        return !m_rst && ((!m_in && m_odd) || (m_in && m_pos == m_len - 32'd1));
    endfunction

    function automatic bit m_trig();
        return enable && (rs0 || rs256) && (m_ft == 8'd0);
    endfunction

    function automatic logic [LW-1:0] exp_bus();
        logic [LW-1:0] v;
        logic [7:0]    b;
        bit            idx;
        b = 8'h00;
        idx = 1'b0;
        if (m_rst)                b = 8'h00;
        else if (!m_in)           b = m_odd ? idle_1 : idle_0;
        else if (m_pos < H) begin
            if (m_pos < 4)        b = 8'(m_hdr >> (8 * m_pos));
            else if (m_pos < 8)   b = 8'(m_seq >> (8 * (m_pos - 4)));
            else if (m_pos == 8)  idx = 1'b1;
        end
        else if (m_pos < m_len - F) b = 8'(m_pat >> (8 * (7 - (m_pos / CR) % 8)));
        else                      b = m_ftr;
        for (int i = 0; i < LW/8; i++) v[8*i +: 8] = idx ? 8'(i) : b;
        return v;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_rst <= 1'b1; m_in <= 1'b0; m_odd <= 1'b0; m_pos <= '0;
            m_ft <= '0; m_frames <= '0; m_und <= 0;
        end else begin
            m_ft <= m_ft + 8'd1;
            if (m_rst) begin
                m_rst <= 1'b0; m_odd <= 1'b0;
            end else if (m_start() && m_trig() && tvalid) begin
                m_in <= 1'b1; m_pos <= '0;
                m_len <= (cpf < H + F + 2) ? 32'(H + F + 2) : cpf;
                m_seq <= m_frames; m_frames <= m_frames + 32'd1;
                m_pat <= {tdata, tdata}; m_hdr <= frame_header; m_ftr <= footer_byte;
            end else if (m_start() && m_trig()) begin
                m_in <= 1'b0; m_odd <= 1'b0;
                if (m_und < 65535) m_und <= m_und + 1;
            end else if (m_in) begin
                if (m_pos == m_len - 32'd1) begin m_in <= 1'b0; m_odd <= 1'b0; end
                else m_pos <= m_pos + 32'd1;
            end else begin
                m_odd <= !m_odd;
            end
        end
    end

    always @(negedge clk) begin
        chk("lvds", lvds, exp_bus());
        chk("sof", sof, m_in && m_pos < H);
        chk("eof", eof, m_in && m_pos >= m_len - F);
        chk("pa_sync", pa_sync, enable && m_ft < PLEN && !m_rst);
        chk("tready", tready, m_start() && m_trig() && tvalid);
        chk("frame_count", frame_count, m_frames);
        chk("underflow_count", underflow_count, 16'(m_und));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_tready(input int limit, input string name);
        int n;
        n = 0;
        while (!tready && n < limit) begin tick(); n++; end
        chk(name, tready, 1'b1);
    endtask

    logic [7:0] lb [0:63], l1 [0:63], top [0:63];
    bit         so [0:63], eo [0:63];

    task automatic record(input int n);
        for (int c = 0; c < n; c++) begin
            lb[c] = lvds[7:0]; l1[c] = lvds[15:8]; top[c] = lvds[LW-1 -: 8];
            so[c] = sof; eo[c] = eof;
            tick();
        end
    endtask

    initial begin
        // Reset: outputs quiet even with enable high.
        enable = 1'b1; rs0 = 1'b1;
        repeat (3) tick();
        chk("rst_lvds", lvds, '0);
        chk("rst_pa_sync", pa_sync, 1'b0);
        chk("rst_frame_count", frame_count, 32'd0);
        chk("rst_underflow", underflow_count, 16'd0);
        enable = 1'b0;
        resetn = 1'b1;
        chk("t1_reset_state", lvds, '0);
        tick(); chk("t1_idle0", lvds[7:0], 8'h55);
        tick(); chk("t1_idle1", lvds[7:0], 8'hAA);
        tick(); chk("t1_idle0b", lvds[7:0], 8'h55);
        repeat (30) tick();

        // Single 64-cycle frame.
        frame_header = 32'hA1B2C3D4; tdata = 32'hA1B2C3D4; tvalid = 1'b1;
        cpf = 32'd64; enable = 1'b1;
        wait_tready(600, "t2_tready");
        chk("t2_pa_sync_at_trigger", pa_sync, 1'b1);
        tick(); rs0 = 1'b0;
        record(64);
        chk("t2_h0", lb[0], 8'hD4); chk("t2_h1", lb[1], 8'hC3);
        chk("t2_h2", lb[2], 8'hB2); chk("t2_h3", lb[3], 8'hA1);
        chk("t2_seq0", lb[4], 8'h00); chk("t2_seq3", lb[7], 8'h00);
        chk("t2_idx1", l1[8], 8'h01); chk("t2_idx63", top[8], 8'h3F);
        chk("t2_h9", lb[9], 8'h00);
        chk("t2_d16", lb[16], 8'hA1); chk("t2_d19", lb[19], 8'hA1);
        chk("t2_d20", lb[20], 8'hB2); chk("t2_d24", lb[24], 8'hC3);
        chk("t2_d28", lb[28], 8'hD4); chk("t2_d32", lb[32], 8'hA1);
        chk("t2_ftr", lb[60], 8'hEE);
        chk("t2_sof15", so[15], 1'b1); chk("t2_sof16", so[16], 1'b0);
        chk("t2_eof59", eo[59], 1'b0); chk("t2_eof60", eo[60], 1'b1);
        chk("t2_eof63", eo[63], 1'b1);
        chk("t2_after", lvds[7:0], 8'h55);
        chk("t2_count", frame_count, 32'd1);

        // Back-to-back 256-cycle frames with sequence numbers 1,2,3.
        cpf = 32'd256; rs0 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_tready(600, "t3_tready");
            tick();
            chk("t3_sof", sof, 1'b1);
            repeat (4) tick();
            chk("t3_seq", lvds[7:0], 8'(f + 1));
            repeat (251) tick();
            chk("t3_eof_last", eof, 1'b1);
            if (f < 2) chk("t3_b2b", tready, 1'b1);
            else rs0 = 1'b0;
        end
        tick();
        chk("t3_count", frame_count, 32'd4);

        // Underflow, then recovery.
        tvalid = 1'b0; rs0 = 1'b1;
        repeat (256) tick();
        chk("t4_underflow", underflow_count, 16'd1);
        chk("t4_count", frame_count, 32'd4);
        tvalid = 1'b1;
        wait_tready(300, "t4_tready");
        tick(); rs0 = 1'b0;
        repeat (256) tick();
        chk("t4_count2", frame_count, 32'd5);

        // Short length clamps to 22; triggered by rs256.
        cpf = 32'd4; rs256 = 1'b1;
        wait_tready(600, "t5_tready");
        tick(); rs256 = 1'b0;
        record(23);
        chk("t5_sof15", so[15], 1'b1); chk("t5_sof16", so[16], 1'b0);
        chk("t5_d16", lb[16], 8'hA1); chk("t5_eof17", eo[17], 1'b0);
        chk("t5_eof18", eo[18], 1'b1); chk("t5_ftr18", lb[18], 8'hEE);
        chk("t5_eof21", eo[21], 1'b1); chk("t5_eof22", eo[22], 1'b0);
        chk("t5_sof22", so[22], 1'b0);

        // Reset during DATA.
        cpf = 32'd64; rs0 = 1'b1;
        wait_tready(600, "t6_tready");
        tick(); rs0 = 1'b0;
        repeat (20) tick();
        chk("t6_in_data", lvds[7:0], 8'hB2);
        resetn = 1'b0; #1;
        chk("t6_lvds", lvds, '0);
        chk("t6_count", frame_count, 32'd0);
        repeat (3) tick();
        resetn = 1'b1;
        chk("t6_reset_state", lvds, '0);
        tick();
        chk("t6_idle0", lvds[7:0], 8'h55);

        // Randomized traffic.
        for (int n = 0; n < 12000; n++) begin
            tick();
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 3))
                    0: cpf = $urandom_range(0, 40);
                    1: cpf = 32'd256;
                    2: cpf = $urandom_range(0, 300) & ~32'd1;
                    default: cpf = 32'd512;
                endcase
            end
            if ($urandom_range(0, 99) < 2)  enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 2)  rs0 = $urandom_range(0, 1);
            if ($urandom_range(0, 99) < 2)  rs256 = $urandom_range(0, 1);
            if ($urandom_range(0, 99) < 10) tvalid = ($urandom_range(0, 3) != 0);
            tdata = $urandom;
            if ($urandom_range(0, 99) < 5) begin idle_0 = 8'($urandom); idle_1 = 8'($urandom); end
            if ($urandom_range(0, 99) < 5) frame_header = $urandom;
            if ($urandom_range(0, 99) < 5) footer_byte = 8'($urandom);
            if (n == 6000 || $urandom_range(0, 4999) == 0) begin
                resetn = 1'b0;
                repeat (2) tick();
                resetn = 1'b1;
            end
        end
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
